// File: rtl/dmux_pkg.sv
// Shared widths and types for the 8-way 16-bit buffered demultiplexer.
package dmux_pkg;
  localparam int WORD_W = 16;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/dmux_slot.sv
// One-entry holding register: loaded word shows on o_valid/o_data after one edge.
// A drain (o_valid & i_ready) empties the slot unless a new word is loaded in the same cycle.
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Load wins over drain, so a draining slot can be refilled without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (r_full && i_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_valid = r_full;
  assign o_data  = r_data;

endmodule

// File: rtl/dmux8way16_buf.sv
// Registered 1-to-8 word demux, one slot per channel; 1-cycle latency, in_ready = !full[d] | out_ready[d].
// DMUX8_AUTO_SEL_EN: destination comes from a round-robin pointer instead of in_sel.
module dmux8way16_buf #(
  parameter int WIDTH  = dmux_pkg::WORD_W,
  parameter int NUM_CH = dmux_pkg::NUM_CH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [2:0]                     in_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_CH-1:0][WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]              out_valid,
  input  logic [NUM_CH-1:0]              out_ready
);

  import dmux_pkg::*;

  sel_t              w_dst;
  logic              w_accept;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_load;

`ifdef DMUX8_AUTO_SEL_EN
  sel_t r_ptr;
  logic w_unused_sel;

  assign w_unused_sel = ^in_sel;

  // The pointer only advances on accept, so a stalled channel holds the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign w_dst = r_ptr;
`else
  assign w_dst = in_sel;
`endif

  assign in_ready  = ~w_full[w_dst] | out_ready[w_dst];
  assign w_accept  = in_valid & in_ready;
  assign out_valid = w_full;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_load[k] = w_accept & (w_dst == SEL_W'(k));

    dmux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[k]),
      .i_data (in_data),
      .i_ready(out_ready[k]),
      .o_valid(w_full[k]),
      .o_data (out_data[k])
    );
  end

endmodule
